// File: rtl/terrain_scroller_if.sv
// Pixel-side signal bundle for terrain_scroller: raster coordinates, control inputs,
// and the registered colour/hit/wrap outputs.
interface terrain_scroller_if #(
  parameter int SPEED_W = 4
);
  logic [15:0]        i_x;
  logic [15:0]        i_y;
  logic               i_v_sync;
  logic               i_active;
  logic               i_state_check;
  logic [SPEED_W-1:0] i_speed;
  logic [7:0]         o_red;
  logic [7:0]         o_green;
  logic [7:0]         o_blue;
  logic               o_sprite_hit;
  logic               o_wrap;
  logic [7:0]         o_wrap_count;

  modport master (
    output i_x, i_y, i_v_sync, i_active, i_state_check, i_speed,
    input  o_red, o_green, o_blue, o_sprite_hit, o_wrap, o_wrap_count
  );

  modport slave (
    input  i_x, i_y, i_v_sync, i_active, i_state_check, i_speed,
    output o_red, o_green, o_blue, o_sprite_hit, o_wrap, o_wrap_count
  );
endinterface

// File: rtl/terrain_scroller.sv
// Scaled 16x16 2-bit terrain slab: per-pixel hit/colour with 1-clock latency,
// plus a once-per-frame diagonal move with respawn when it leaves the playfield.
module terrain_scroller #(
  parameter int          SCALE_X_SHIFT = 4,
  parameter int          SCALE_Y_SHIFT = 1,
  parameter int          DIR_X         = 0,
  parameter int          DIR_Y         = 1,
  parameter int          START_X       = 144,
  parameter int          START_Y       = 390,
  parameter int          RESPAWN_X     = 180,
  parameter int          RESPAWN_Y     = 360,
  parameter int          SCREEN_W      = 1280,
  parameter int          SCREEN_H      = 720,
  parameter int          SPEED_W       = 4,
  parameter logic [23:0] COLOR_FG      = 24'hA0A0A0
) (
  input logic               i_clk,
  input logic               i_rst,
  terrain_scroller_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FROZEN = 2'd2;

  // Slab occupies rows 5..10; index 0 is transparent.
  function automatic logic [1:0] bitmap(input logic [3:0] r, input logic [3:0] c);
    case (r)
      4'd5, 4'd10: bitmap = (c >= 4'd2 && c <= 4'd13) ? 2'd1 : 2'd0;
      4'd6, 4'd9:  bitmap = (c >= 4'd1 && c <= 4'd14) ? 2'd2 : 2'd0;
      4'd7, 4'd8:  bitmap = 2'd3;
      default:     bitmap = 2'd0;
    endcase
  endfunction

  logic [1:0] rom [256];
  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    assign rom[gi] = bitmap(4'(gi / 16), 4'(gi % 16));
  end

  logic [15:0]        x_reg, y_reg;
  logic [1:0]         state_reg, state_next;
  logic               v_sync_q_reg;
  logic [7:0]         red_reg, green_reg, blue_reg;
  logic               hit_reg, wrap_reg;
  logic [7:0]         wrap_count_reg;
  logic [SPEED_W-1:0] speed;
  logic               tick, do_move, respawn;
  logic [16:0]        nx, ny, x_end, y_end;
  logic               hit_x, hit_y, pix_on;
  logic [15:0]        dx, dy;
  logic [3:0]         col, row;
  logic [1:0]         idx;

  assign speed = bus.i_speed;
  assign tick  = bus.i_v_sync & ~v_sync_q_reg;

  assign nx = (DIR_X != 0) ? ({1'b0, x_reg} + 17'(speed)) : ({1'b0, x_reg} - 17'(speed));
  assign ny = (DIR_Y != 0) ? ({1'b0, y_reg} + 17'(speed)) : ({1'b0, y_reg} - 17'(speed));
  // Bit 16 is the borrow of a decrement below zero.
  assign respawn = nx[16] | (nx >= 17'(SCREEN_W)) | ny[16] | (ny >= 17'(SCREEN_H));

  always_comb begin
    state_next = state_reg;
    do_move    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick && bus.i_active && !bus.i_state_check) begin
          state_next = RUN;
          do_move    = 1'b1;
        end
      end
      RUN: begin
        if (!bus.i_active)          state_next = IDLE;
        else if (bus.i_state_check) state_next = FROZEN;
        else if (tick)              do_move    = 1'b1;
      end
      FROZEN: begin
        if (!bus.i_active)           state_next = IDLE;
        else if (!bus.i_state_check) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign x_end  = {1'b0, x_reg} + (17'd16 << SCALE_X_SHIFT);
  assign y_end  = {1'b0, y_reg} + (17'd16 << SCALE_Y_SHIFT);
  assign hit_x  = ({1'b0, bus.i_x} >= {1'b0, x_reg}) && ({1'b0, bus.i_x} < x_end);
  assign hit_y  = ({1'b0, bus.i_y} >= {1'b0, y_reg}) && ({1'b0, bus.i_y} < y_end);
  assign dx     = bus.i_x - x_reg;
  assign dy     = bus.i_y - y_reg;
  assign col    = 4'(dx >> SCALE_X_SHIFT);
  assign row    = 4'(dy >> SCALE_Y_SHIFT);
  assign idx    = rom[{row, col}];
  assign pix_on = hit_x && hit_y && (idx != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_reg          <= 16'(START_X);
      y_reg          <= 16'(START_Y);
      state_reg      <= IDLE;
      v_sync_q_reg   <= 1'b0;
      red_reg        <= 8'd0;
      green_reg      <= 8'd0;
      blue_reg       <= 8'd0;
      hit_reg        <= 1'b0;
      wrap_reg       <= 1'b0;
      wrap_count_reg <= 8'd0;
    end else begin
      v_sync_q_reg <= bus.i_v_sync;
      state_reg    <= state_next;
      wrap_reg     <= 1'b0;
      if (do_move) begin
        if (respawn) begin
          x_reg    <= 16'(RESPAWN_X);
          y_reg    <= 16'(RESPAWN_Y);
          wrap_reg <= 1'b1;
          if (wrap_count_reg != 8'hFF) wrap_count_reg <= wrap_count_reg + 8'd1;
        end else begin
          x_reg <= nx[15:0];
          y_reg <= ny[15:0];
        end
      end
      hit_reg   <= pix_on;
      red_reg   <= pix_on ? COLOR_FG[23:16] : 8'd0;
      green_reg <= pix_on ? COLOR_FG[15:8]  : 8'd0;
      blue_reg  <= pix_on ? COLOR_FG[7:0]   : 8'd0;
    end
  end

  assign bus.o_red        = red_reg;
  assign bus.o_green      = green_reg;
  assign bus.o_blue       = blue_reg;
  assign bus.o_sprite_hit = hit_reg;
  assign bus.o_wrap       = wrap_reg;
  assign bus.o_wrap_count = wrap_count_reg;
endmodule

// File: tb/tb_terrain_scroller.sv
// Scoreboard bench for terrain_scroller: a reference position/FSM model queues the
// expected outputs per driven cycle; each queued entry is compared after the edge.
module tb_terrain_scroller;
  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  terrain_scroller_if #(.SPEED_W(4)) bus ();

  terrain_scroller dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    bit chk_pix;
    bit hit;
    bit wrap;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus controls, applied on the next driven cycle
  bit       rst_v  = 1'b1;
  bit       active = 1'b0;
  bit       sc     = 1'b0;
  bit [3:0] speed  = 4'd0;

  // Reference model
  int m_x = 144, m_y = 390, m_state = 0, m_cnt = 0, total_wraps = 0;
  bit m_vq = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (model pos %0d,%0d)", tag, obs, exp, m_x, m_y);
    end
  endtask

  task automatic step(input int ix, input int iy, input bit vs, input bit chk, input bit ehit);
    exp_t e, o;
    bit   tick, mv;
    int   nx, ny;
    @(negedge clk);
    i_rst             = rst_v;
    bus.i_x           = 16'(ix);
    bus.i_y           = 16'(iy);
    bus.i_v_sync      = vs;
    bus.i_active      = active;
    bus.i_state_check = sc;
    bus.i_speed       = speed;
    tick      = vs && !m_vq;
    mv        = 1'b0;
    e.chk_pix = chk;
    e.hit     = rst_v ? 1'b0 : ehit;
    e.wrap    = 1'b0;
    if (rst_v) begin
      m_x = 144; m_y = 390; m_state = 0; m_cnt = 0; m_vq = 1'b0;
    end else begin
      case (m_state)
        0: if (tick && active && !sc) begin m_state = 1; mv = 1'b1; end
        1: if (!active) m_state = 0; else if (sc) m_state = 2; else if (tick) mv = 1'b1;
        default: if (!active) m_state = 0; else if (!sc) m_state = 1;
      endcase
      if (mv) begin
        nx = m_x - int'(speed);
        ny = m_y + int'(speed);
        if (nx < 0 || nx >= 1280 || ny < 0 || ny >= 720) begin
          m_x = 180; m_y = 360; e.wrap = 1'b1; total_wraps++;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
      m_vq = vs;
    end
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    check("wrap", int'(bus.o_wrap), int'(o.wrap));
    check("wrap_count", int'(bus.o_wrap_count), o.cnt);
    if (o.chk_pix) begin
      check("sprite_hit", int'(bus.o_sprite_hit), int'(o.hit));
      check("red", int'(bus.o_red), o.hit ? 160 : 0);
      check("green", int'(bus.o_green), o.hit ? 160 : 0);
      check("blue", int'(bus.o_blue), o.hit ? 160 : 0);
    end
  endtask

  task automatic frame();
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pins the slab position exactly: one pixel inside (row 8, col 8) and the
  // four pixels just beyond each edge of the 256x32 footprint.
  task automatic probe_pos();
    int px, py;
    px = m_x; py = m_y;
    step(px + 128, py + 16, 1'b0, 1'b1, 1'b1);
    if (px > 0) step(px - 1, py + 16, 1'b0, 1'b1, 1'b0);
    step(px + 256, py + 16, 1'b0, 1'b1, 1'b0);
    if (py > 0) step(px + 128, py - 1, 1'b0, 1'b1, 1'b0);
    step(px + 128, py + 32, 1'b0, 1'b1, 1'b0);
    $display("probe pos model=(%0d,%0d) wraps=%0d", px, py, m_cnt);
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_x = '0; bus.i_y = '0; bus.i_v_sync = 1'b0;
    bus.i_active = 1'b0; bus.i_state_check = 1'b0; bus.i_speed = '0;

    // Reset: outputs forced low even with a hitting coordinate presented
    rst_v = 1'b1;
    step(272, 406, 1'b0, 1'b1, 1'b1);
    step(272, 406, 1'b1, 1'b1, 1'b1);
    rst_v = 1'b0;

    // Tick while inactive does not move
    frame();
    probe_pos();
    step(272, 390, 1'b0, 1'b1, 1'b0);  // row 0 transparent
    step(143, 406, 1'b0, 1'b1, 1'b0);  // left of footprint
    step(192, 400, 1'b0, 1'b1, 1'b1);  // row 5 col 3 = index 1
    step(160, 408, 1'b0, 1'b1, 1'b1);  // row 9 col 1 = index 2

    // Single move, then run to the left edge and wrap
    active = 1'b1; speed = 4'd1;
    frame();
    probe_pos();
    for (int i = 0; i < 143; i++) frame();
    probe_pos();
    frame();
    probe_pos();

    // Freeze: tick coincident with the freeze request is dropped
    sc = 1'b1;
    for (int i = 0; i < 6; i++) frame();
    probe_pos();
    sc = 1'b0;
    step(0, 0, 1'b0, 1'b0, 1'b0);
    frame();
    probe_pos();

    // Zero speed: no motion, no wrap
    speed = 4'd0;
    for (int i = 0; i < 10; i++) frame();
    probe_pos();

    // Saturate the wrap counter
    speed = 4'd15;
    for (int i = 0; i < 20000 && total_wraps < 300; i++) frame();
    check("wraps_reached", total_wraps >= 300 ? 1 : 0, 1);
    check("wrap_count_sat", int'(bus.o_wrap_count), 255);

    // Mid-run reset coincident with a tick
    rst_v = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b0);
    rst_v = 1'b0;
    speed = 4'd1;
    for (int i = 0; i < 44; i++) frame();
    probe_pos();
    rst_v = 1'b1;
    step(m_x + 128, m_y + 16, 1'b1, 1'b1, 1'b1);
    rst_v = 1'b0;
    active = 1'b0;
    probe_pos();
    frame();
    probe_pos();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/terrain_scroller.md
# terrain_scroller

Parametrised terrain slab generator for the arcade video pipeline. It renders one 16×16, 2-bit-palette bitmap scaled onto the 1280×720 raster and reports a per-pixel hit for the compositor and collision logic. Once per frame it moves the slab by a programmable speed in a parameter-selected diagonal direction, and respawns it when it leaves the screen. All logic runs on the pixel clock; `i_v_sync` is only sampled as a frame strobe.

## Interface
- `SCALE_X_SHIFT`, 4: horizontal magnification is 2^n, so the footprint width is 16<<n pixels.
- `SCALE_Y_SHIFT`, 1: vertical magnification is 2^n, so the footprint height is 16<<n pixels.
- `DIR_X`, 0: 0 moves left (x decrements); 1 moves right.
- `DIR_Y`, 1: 0 moves up; 1 moves down.
- `START_X`, 144 / `START_Y`, 390: position loaded on reset.
- `RESPAWN_X`, 180 / `RESPAWN_Y`, 360: position loaded on exit.
- `SCREEN_W`, 1280 / `SCREEN_H`, 720: playfield bounds.
- `SPEED_W`, 4: width of the speed input.
- `COLOR_FG`, 24'hA0A0A0: RGB used for palette indices 1, 2 and 3.
- `i_clk`  in  1  pixel clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_x`, `i_y`  in  16 each  current raster coordinate.
- `i_v_sync`  in  1  frame sync; a rising edge is a frame tick.
- `i_active`  in  1  motion enable (sw[0]).
- `i_state_check`  in  1  game-state freeze request; 1 means freeze.
- `i_speed`  in  SPEED_W  pixels moved per frame on each axis.
- `o_red`, `o_green`, `o_blue`  out  8 each  registered pixel colour.
- `o_sprite_hit`  out  1  registered; high for a non-transparent slab pixel.
- `o_wrap`  out  1  one-cycle pulse on respawn.
- `o_wrap_count`  out  8  number of respawns, saturating.

## Operation
- **Bitmap:** fixed internal 16×16×2 ROM. Rows 0–4 and 11–15 are 0. Rows 5–10 form the slab; for example (r5,c3)=1, (r8,c8)=3, (r9,c1)=2. Palette index 0 is transparent black; indices 1–3 are `COLOR_FG`.
- **Frame tick:** `tick = i_v_sync & ~v_sync_q`, where `v_sync_q` is registered every clock.
- **FSM states:** IDLE, RUN, FROZEN.
  - IDLE → RUN on a tick with `i_active`=1 and `i_state_check`=0. The movement is applied on that same tick.
  - RUN → FROZEN when `i_state_check`=1; this is evaluated every clock. RUN → IDLE when `i_active`=0.
  - FROZEN → RUN when `i_state_check`=0 and `i_active`=1. FROZEN → IDLE when `i_active`=0.
  - Position updates only on a tick while in RUN, or on the IDLE→RUN tick. IDLE and FROZEN hold the position.
- **Move arithmetic:** computed on 17 bits.
  - nx = x ± speed according to `DIR_X`; ny = y ± speed according to `DIR_Y`.
  - Respawn if nx<0 (borrow), nx≥SCREEN_W, ny<0, or ny≥SCREEN_H.
  - On respawn, load `RESPAWN_X`/`RESPAWN_Y`, pulse `o_wrap`, and increment `o_wrap_count`, saturating at 255.
  - Otherwise x=nx[15:0] and y=ny[15:0].
  - `i_speed`=0 leaves the position unchanged and never wraps.
- **Pixel path:**
  - hit_x = `i_x`≥x && `i_x` < x+(16<<`SCALE_X_SHIFT`); the sum is taken at 17 bits so it cannot overflow. hit_y is the same on the vertical axis.
  - col = (`i_x`−x)>>`SCALE_X_SHIFT`; row = (`i_y`−y)>>`SCALE_Y_SHIFT`.
  - Inside the footprint, the RGB outputs are the palette colour of the bitmap entry. Outside, RGB is 0; outputs are never X.
  - `o_sprite_hit` = hit_x && hit_y && palette index ≠ 0.
- **Reset:**
  - Loads x=`START_X`, y=`START_Y`, state IDLE, `v_sync_q`=0.
  - All outputs go to 0: RGB=0, `o_sprite_hit`=0, `o_wrap`=0, `o_wrap_count`=0.
  - Reset wins over a simultaneous tick.

## Timing
- Pixel latency is 1 clock: outputs at cycle n+1 reflect `i_x`/`i_y` at cycle n, computed against the position held at cycle n.
- Position registers update at the end of the tick cycle; the first pixel using the new position is sampled the cycle after the tick.
- `o_wrap` is high for exactly the clock after the tick that caused the respawn.
- A tick coinciding with `i_state_check` rising is not applied: the freeze takes priority.
- Reset asserted mid-run takes effect on the next edge. Position returns to START, and the pixel outputs are 0 on the following cycle.
- Back-to-back ticks (`i_v_sync` toggling every 2 clocks) each move the slab.

## Test plan
- **Reset:** assert `i_rst` for 2 clocks → all outputs are 0, position is (144,390), state is IDLE; a tick with `i_active`=0 leaves the position at (144,390).
- **Single move:** `i_active`=1, `i_speed`=1, defaults, one tick → position (143,391); `o_wrap`=0.
- **Pixel hit:** position (144,390).
  - `i_x`=144+8·16=272, `i_y`=390+8·2=406 → on the next clock `o_sprite_hit`=1 and RGB=A0/A0/A0.
  - `i_y`=390 (row 0) → hit=0, RGB=0.
  - `i_x`=143 → hit=0.
- **Wrap:** `i_speed`=1.
  - After 144 ticks, position is (0,534).
  - Tick 145 → position (180,360), `o_wrap` high for 1 clock, `o_wrap_count`=1.
  - Run 300 wraps → count saturates at 255.
- **Freeze:** with `i_state_check`=1 through 5 ticks, position is unchanged; release it → the next tick moves by `i_speed`. With `i_speed`=0, 10 ticks → no motion and no wrap.
- **Mid-run reset:** at position (100,434), pulse `i_rst` coincident with a tick → position (144,390), count 0, IDLE, `o_wrap`=0.
